// File: rtl/ttt_pkg.sv
// Shared types, board geometry and helpers for the tic-tac-toe move-entry front end.
package ttt_pkg;

   localparam int unsigned COORD_W = 4;
   localparam int unsigned BOARD_W = 18;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   localparam int unsigned NUM_BTN   = 5;
   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_DOWN  = 1;
   localparam int unsigned BTN_LEFT  = 2;
   localparam int unsigned BTN_RIGHT = 3;
   localparam int unsigned BTN_SEL   = 4;

   typedef enum logic [1:0] {
      StReady,
      StIssue,
      StHold
   } move_state_e;

   // Cell (r,c) occupies board[17-2*(3r+c) -: 2]; its low bit sits at 2*(8-(3r+c)).
   function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] board,
                                          input logic [1:0]         r,
                                          input logic [1:0]         c);
      int                 k;
      logic [BOARD_W-1:0] sh;
      k  = 3 * int'(r) + int'(c);
      sh = board >> (2 * (8 - k));
      return sh[1:0];
   endfunction

   function automatic logic [1:0] wrap_step(input logic [1:0] v,
                                            input logic       inc,
                                            input logic       dec);
      logic [1:0] r;
      r = v;
      if (inc && !dec) begin
         r = (v == 2'd2) ? 2'd0 : v + 2'd1;
      end else if (dec && !inc) begin
         r = (v == 2'd0) ? 2'd2 : v - 2'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ttt_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, counting debouncer, rising-edge press pulse.
// Optional auto-repeat when TTT_AUTOREPEAT_EN is defined.
module ttt_btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_CYCLES   = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic rep_en,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_prev_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rep_hit;

`ifdef TTT_AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt_q;
   logic             rep_run;

   // Counting starts the cycle after the first press, so repeats land every REPEAT_CYCLES.
   assign rep_run = rep_en & stable_q & stable_prev_q;
   assign rep_hit = rep_run & (rep_cnt_q == REP_MAX);

   always_ff @(posedge clk) begin
      if (rst || !rep_run || rep_hit) begin
         rep_cnt_q <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_q + 1'b1;
      end
   end
`else
   logic unused_rep_en;
   assign unused_rep_en = rep_en;
   assign rep_hit       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         press_q       <= 1'b0;
         cnt_q         <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         stable_prev_q <= stable_q;
         press_q       <= (stable_q & ~stable_prev_q) | rep_hit;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/ttt_move_input.sv
// Move-entry front end: five conditioned buttons drive a 3x3 cursor and a select FSM that
// strobes make_move into the game core. Optional auto-repeat: define TTT_AUTOREPEAT_EN.
module ttt_move_input
   import ttt_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned HOLD_TIMEOUT    = 8,
   parameter int unsigned REPEAT_CYCLES   = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               btn_sel,
   input  logic [BOARD_W-1:0] board,
   input  logic               game_over,
   output logic [COORD_W-1:0] x_out,
   output logic [COORD_W-1:0] y_out,
   output logic               make_move,
   output logic               reject,
   output logic               busy
);

   localparam int unsigned HOLD_W = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TIMEOUT - 1);

   logic [NUM_BTN-1:0] raw;
   logic [NUM_BTN-1:0] press;

   move_state_e        state_q, state_d;
   logic [1:0]         x_q, x_d, y_q, y_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic               reject_q, reject_d;
   logic [1:0]         cur_cell;

   assign raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      ttt_btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .btn_raw(raw[i]),
         .rep_en (i != BTN_SEL),
         .press  (press[i])
      );
   end

   assign cur_cell = cell_at(board, y_q, x_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StReady;
         x_q        <= 2'd0;
         y_q        <= 2'd0;
         hold_cnt_q <= '0;
         reject_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         hold_cnt_q <= hold_cnt_d;
         reject_q   <= reject_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      hold_cnt_d = hold_cnt_q;
      reject_d   = 1'b0;
      case (state_q)
         StReady: begin
            x_d = wrap_step(x_q, press[BTN_RIGHT], press[BTN_LEFT]);
            y_d = wrap_step(y_q, press[BTN_DOWN], press[BTN_UP]);
            if (press[BTN_SEL] && !game_over) begin
               if (cur_cell != CELL_EMPTY) begin
                  reject_d = 1'b1;
               end else begin
                  // Accepted move uses the pre-move cursor, which must hold through the strobe.
                  state_d = StIssue;
                  x_d     = x_q;
                  y_d     = y_q;
               end
            end
         end
         StIssue: begin
            state_d    = StHold;
            hold_cnt_d = '0;
         end
         StHold: begin
            if (cur_cell != CELL_EMPTY || game_over || hold_cnt_q == HOLD_MAX) begin
               state_d = StReady;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = StReady;
      endcase
   end

   assign x_out     = COORD_W'(x_q);
   assign y_out     = COORD_W'(y_q);
   assign make_move = (state_q == StIssue);
   assign busy      = (state_q != StReady);
   assign reject    = reject_q;

endmodule

// File: tb/tb_ttt_move_input.sv
// Self-checking bench for ttt_move_input: directed scenarios plus a randomized cursor/select
// phase checked against a modulo-3 cursor and 9-cell board model acting as the game core.
module tb_ttt_move_input;
   import ttt_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [4:0]         btn;
   logic [BOARD_W-1:0] board;
   logic               game_over;
   logic [COORD_W-1:0] x_out, y_out;
   logic               make_move, reject, busy;

   logic [1:0] cells [9];
   int errors = 0;
   int checks = 0;
   int mm_cnt, rej_cnt, mm_x, mm_y;
   bit core_en;

   always #5 clk = ~clk;

   always_comb begin
      board = '0;
      for (int k = 0; k < 9; k++) board[17-2*k -: 2] = cells[k];
   end

   ttt_move_input #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_TIMEOUT   (8),
      .REPEAT_CYCLES  (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_up   (btn[0]),
      .btn_down (btn[1]),
      .btn_left (btn[2]),
      .btn_right(btn[3]),
      .btn_sel  (btn[4]),
      .board    (board),
      .game_over(game_over),
      .x_out    (x_out),
      .y_out    (y_out),
      .make_move(make_move),
      .reject   (reject),
      .busy     (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_cells();
      for (int k = 0; k < 9; k++) cells[k] = CELL_EMPTY;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Counts strobes; when core_en is set, the bench plays the core and marks the cell.
   task automatic sample();
      int k;
      if (make_move === 1'b1) begin
         mm_cnt++;
         mm_x = int'(x_out);
         mm_y = int'(y_out);
         k    = 3 * mm_y + mm_x;
         if (core_en && k < 9) cells[k] = CELL_P1;
      end
      if (reject === 1'b1) rej_cnt++;
   endtask

   task automatic press(input logic [4:0] mask);
      mm_cnt  = 0;
      rej_cnt = 0;
      btn     = mask;
      for (int i = 0; i < 10; i++) begin step(); sample(); end
      btn = '0;
      for (int i = 0; i < 10; i++) begin step(); sample(); end
   endtask

   task automatic wait_make_move(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (make_move === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat, changes, busy_cycles, mx, my, dx, dy, k, exp_mm, exp_rej, exp_changes, full;
      logic [3:0] prev;
      logic [3:0] dmask;
      core_en   = 1'b0;
      game_over = 1'b0;
      clear_cells();
      do_reset();

      check("reset_x", 32'(x_out), 0);
      check("reset_y", 32'(y_out), 0);
      check("reset_make_move", 32'(make_move), 0);
      check("reset_reject", 32'(reject), 0);
      check("reset_busy", 32'(busy), 0);

      // 1: held right gives one press 7 clocks in; cursor moves the following cycle
      btn[3]  = 1'b1;
      changes = 0;
      prev    = x_out;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (x_out !== prev) changes++;
         prev = x_out;
         if (i == 8) check("t1_x_at8", 32'(x_out), 1);
         if (i == 7) check("t1_x_at7", 32'(x_out), 0);
      end
      btn = '0;
      for (int i = 0; i < 10; i++) step();
      check("t1_one_press", 32'(changes), 1);
      for (int g = 0; g < 3; g++) begin
         btn[3] = 1'b1;
         step();
         step();
         btn = '0;
         for (int i = 0; i < 6; i++) step();
      end
      check("t1_glitch_x", 32'(x_out), 1);

      // 2: wrap and opposing presses
      do_reset();
      press(5'b00100); check("t2_left1", 32'(x_out), 2);
      press(5'b00100); check("t2_left2", 32'(x_out), 1);
      press(5'b00100); check("t2_left3", 32'(x_out), 0);
      press(5'b00010); check("t2_down", 32'(y_out), 1);
      press(5'b00011); check("t2_updown", 32'(y_out), 1);

      // 3: accepted move at (row1,col2), core answers two cycles after the strobe
      do_reset();
      clear_cells();
      press(5'b00010);
      press(5'b00100);
      btn = 5'b10000;
      wait_make_move(lat);
      check("t3_latency", 32'(lat), 8);
      check("t3_x", 32'(x_out), 2);
      check("t3_y", 32'(y_out), 1);
      check("t3_busy_issue", 32'(busy), 1);
      step();
      check("t3_mm_single", 32'(make_move), 0);
      check("t3_busy_hold", 32'(busy), 1);
      step();
      cells[5] = CELL_P1;
      check("t3_busy_before", 32'(busy), 1);
      step();
      check("t3_busy_done", 32'(busy), 0);
      btn = '0;
      for (int i = 0; i < 10; i++) step();

      // 4: occupied cell rejects; game over suppresses both pulses
      do_reset();
      clear_cells();
      cells[0] = CELL_P2;
      press(5'b10000);
      check("t4_reject", 32'(rej_cnt), 1);
      check("t4_no_mm", 32'(mm_cnt), 0);
      game_over = 1'b1;
      press(5'b10000);
      check("t4_go_reject", 32'(rej_cnt), 0);
      check("t4_go_mm", 32'(mm_cnt), 0);
      cells[0] = CELL_EMPTY;
      press(5'b10000);
      check("t4_go_empty_mm", 32'(mm_cnt), 0);
      game_over = 1'b0;

      // 5: frozen board times out HOLD; right pressed during HOLD is discarded
      do_reset();
      clear_cells();
      btn = 5'b10000;
      wait_make_move(lat);
      check("t5_mm_seen", 32'(lat), 8);
      btn         = 5'b11000;
      busy_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (busy !== 1'b1) break;
         busy_cycles++;
      end
      check("t5_hold_cycles", 32'(busy_cycles), 8);
      btn = '0;
      for (int i = 0; i < 10; i++) step();
      check("t5_x_unchanged", 32'(x_out), 0);

      // 6: reset during the strobe cycle
      do_reset();
      clear_cells();
      press(5'b01000);
      press(5'b00010);
      btn = 5'b10000;
      wait_make_move(lat);
      check("t6_mm_seen", 32'(make_move), 1);
      rst = 1'b1;
      btn = '0;
      step();
      check("t6_mm", 32'(make_move), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_x", 32'(x_out), 0);
      check("t6_y", 32'(y_out), 0);
      check("t6_reject", 32'(reject), 0);
      rst     = 1'b0;
      mm_cnt  = 0;
      rej_cnt = 0;
      for (int i = 0; i < 10; i++) begin step(); sample(); end
      check("t6_no_late_mm", 32'(mm_cnt), 0);

      // 6b: down held 40 cycles past its first press
      do_reset();
      btn[1]  = 1'b1;
      changes = 0;
      prev    = y_out;
      for (int i = 1; i <= 47; i++) begin
         step();
         if (y_out !== prev) changes++;
         prev = y_out;
      end
      btn = '0;
      for (int i = 0; i < 10; i++) step();
`ifdef TTT_AUTOREPEAT_EN
      exp_changes = 3;
`else
      exp_changes = 1;
`endif
      check("t6_repeat_presses", 32'(changes), 32'(exp_changes));

      // Randomized: cursor arithmetic mod 3 and select outcome against the board model
      do_reset();
      clear_cells();
      core_en = 1'b1;
      mx = 0;
      my = 0;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 3) != 0) begin
            dmask = 4'($urandom_range(1, 15));
            press({1'b0, dmask});
            dx = int'(dmask[3]) - int'(dmask[2]);
            dy = int'(dmask[1]) - int'(dmask[0]);
            mx = (mx + dx + 3) % 3;
            my = (my + dy + 3) % 3;
            check("rnd_x", 32'(x_out), 32'(mx));
            check("rnd_y", 32'(y_out), 32'(my));
            check("rnd_dir_mm", 32'(mm_cnt), 0);
         end else begin
            full = 1;
            for (int c = 0; c < 9; c++) if (cells[c] == CELL_EMPTY) full = 0;
            if (full != 0) clear_cells();
            k = 3 * my + mx;
            if ($urandom_range(0, 2) == 0) cells[k] = ($urandom_range(0, 1) != 0) ? CELL_P1 : CELL_P2;
            game_over = ($urandom_range(0, 4) == 0);
            exp_mm  = (!game_over && cells[k] == CELL_EMPTY) ? 1 : 0;
            exp_rej = (!game_over && cells[k] != CELL_EMPTY) ? 1 : 0;
            press(5'b10000);
            check("rnd_sel_mm", 32'(mm_cnt), 32'(exp_mm));
            check("rnd_sel_rej", 32'(rej_cnt), 32'(exp_rej));
            if (exp_mm == 1 && mm_cnt == 1) begin
               check("rnd_mm_x", 32'(mm_x), 32'(mx));
               check("rnd_mm_y", 32'(mm_y), 32'(my));
            end
            check("rnd_sel_busy", 32'(busy), 0);
            game_over = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
